// File: rtl/i2s_capture_writer_pkg.sv
// Shared widths and FSM state type for the I2S capture writer.
// Audio RAM word address is {chan, wr_ptr}.
package i2s_capture_writer_pkg;

  localparam int CHAN_W       = 4;
  localparam int POS_W        = 6;
  localparam int AUDIO_ADDR_W = CHAN_W + POS_W;
  localparam int SAMPLE_W_DEF = 16;
  localparam int MAX_CHAN     = 1 << CHAN_W;
  localparam int BIT_CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/i2s_capture_writer_if.sv
// Audio RAM write port between the capture writer (master) and the audio engine RAM (slave).
// The RAM accepts one word per cycle, so there is no ready signal.
interface i2s_capture_writer_if #(
  parameter int SAMPLE_W = 16
);
  import i2s_capture_writer_pkg::*;

  logic                    ram_we;
  logic [AUDIO_ADDR_W-1:0] ram_addr;
  logic [SAMPLE_W-1:0]     ram_wdata;

  modport master (output ram_we, output ram_addr, output ram_wdata);
  modport slave  (input  ram_we, input  ram_addr, input  ram_wdata);

endinterface

// File: rtl/i2s_capture_writer_line_rx.sv
// One I2S data line: slot bit counter, MSB-first shift register, left/right holds and
// the pair_valid flag that qualifies a frame for capture once a full L then R slot was seen while armed.
module i2s_capture_writer_line_rx
  import i2s_capture_writer_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                i_ck,
  input  logic                i_rst,
  input  logic                i_sck_rise,
  input  logic                i_ws,
  input  logic                i_sd,
  input  logic                i_arm,
  output logic [SAMPLE_W-1:0] o_hold_l,
  output logic [SAMPLE_W-1:0] o_hold_r,
  output logic                o_pair_valid
);

  localparam logic [BIT_CNT_W-1:0] CNT_LAST = BIT_CNT_W'(SAMPLE_W);
  localparam logic [BIT_CNT_W-1:0] CNT_SAT  = '1;

  logic                 r_ws_prev;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [SAMPLE_W-1:0]  r_shift;
  logic [SAMPLE_W-1:0]  r_hold_l;
  logic [SAMPLE_W-1:0]  r_hold_r;
  logic                 r_l_started;
  logic                 r_got_l;
  logic                 r_pair_valid;

  logic                 w_slot_start;
  logic [BIT_CNT_W-1:0] w_cnt_nxt;
  logic [SAMPLE_W-1:0]  w_shift_nxt;
  logic                 w_in_word;

  assign w_slot_start = (i_ws != r_ws_prev);
  assign w_cnt_nxt    = w_slot_start ? '0 :
                        (r_bit_cnt == CNT_SAT) ? CNT_SAT : r_bit_cnt + 1'b1;
  assign w_shift_nxt  = {r_shift[SAMPLE_W-2:0], i_sd};
  // count 0 carries the previous slot's last bit (one-bit I2S delay)
  assign w_in_word    = (w_cnt_nxt != '0) && (w_cnt_nxt <= CNT_LAST);

  always_ff @(posedge i_ck or negedge i_rst) begin
    if (!i_rst) begin
      r_ws_prev    <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_l_started  <= 1'b0;
      r_got_l      <= 1'b0;
      r_pair_valid <= 1'b0;
    end else begin
      if (!i_arm) begin
        r_l_started  <= 1'b0;
        r_got_l      <= 1'b0;
        r_pair_valid <= 1'b0;
      end
      if (i_sck_rise) begin
        r_ws_prev <= i_ws;
        r_bit_cnt <= w_cnt_nxt;
        if (w_in_word) begin
          r_shift <= w_shift_nxt;
        end
        if (w_slot_start && !i_ws && i_arm) begin
          r_l_started <= 1'b1;
        end
        if (w_cnt_nxt == CNT_LAST) begin
          if (i_ws) begin
            r_hold_r <= w_shift_nxt;
            if (i_arm && r_got_l) begin
              r_pair_valid <= 1'b1;
            end
          end else begin
            r_hold_l <= w_shift_nxt;
            if (i_arm && r_l_started) begin
              r_got_l <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign o_hold_l     = r_hold_l;
  assign o_hold_r     = r_hold_r;
  assign o_pair_valid = r_pair_valid;

endmodule

// File: rtl/i2s_capture_writer.sv
// Deserialises NLINES I2S lines and writes each stereo frame into audio RAM at {chan, wr_ptr}.
// Optional I2S_TEST_PATTERN_EN adds i_test_mode, which replaces captured samples by {chan, 6'b0, wr_ptr}.
module i2s_capture_writer
  import i2s_capture_writer_pkg::*;
#(
  parameter int NLINES   = 4,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic              i_ck,
  input  logic              i_rst,
  input  logic              i_sck,
  input  logic              i_ws,
  input  logic [NLINES-1:0] i_sd,
  input  logic              i_enable,
  input  logic              i_clr,
`ifdef I2S_TEST_PATTERN_EN
  input  logic              i_test_mode,
`endif
  i2s_capture_writer_if.master ram,
  output logic [POS_W-1:0]  o_wr_ptr,
  output logic              o_frame,
  output logic              o_overrun
);

  localparam int                  CHANNELS  = 2 * NLINES;
  localparam logic [CHAN_W-1:0]   CHAN_LAST = CHAN_W'(CHANNELS - 1);

  logic              r_sck_s1, r_sck_s2, r_sck_d;
  logic              r_ws_s1, r_ws_s2, r_ws_prev;
  logic [NLINES-1:0] r_sd_s1, r_sd_s2;

  wr_state_t               r_state;
  logic [CHAN_W-1:0]       r_chan;
  logic [POS_W-1:0]        r_wr_ptr;
  logic                    r_frame;
  logic                    r_overrun;
  logic                    r_ram_we;
  logic [AUDIO_ADDR_W-1:0] r_ram_addr;
  logic [SAMPLE_W-1:0]     r_ram_wdata;
  logic [SAMPLE_W-1:0]     r_stage [MAX_CHAN];

  logic                w_sck_rise;
  logic                w_frame_cmp;
  logic                w_pair_all;
  logic [CHAN_W-1:0]   w_chan_nxt;
  logic [NLINES-1:0]   w_pair_valid;
  logic [SAMPLE_W-1:0] w_hold_l [NLINES];
  logic [SAMPLE_W-1:0] w_hold_r [NLINES];
  logic [SAMPLE_W-1:0] w_latch  [MAX_CHAN];

  always_ff @(posedge i_ck or negedge i_rst) begin
    if (!i_rst) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_d   <= 1'b0;
      r_ws_s1   <= 1'b0;
      r_ws_s2   <= 1'b0;
      r_ws_prev <= 1'b0;
      r_sd_s1   <= '0;
      r_sd_s2   <= '0;
    end else begin
      r_sck_s1 <= i_sck;
      r_sck_s2 <= r_sck_s1;
      r_sck_d  <= r_sck_s2;
      r_ws_s1  <= i_ws;
      r_ws_s2  <= r_ws_s1;
      r_sd_s1  <= i_sd;
      r_sd_s2  <= r_sd_s1;
      if (w_sck_rise) begin
        r_ws_prev <= r_ws_s2;
      end
    end
  end

  assign w_sck_rise  = r_sck_s2 & ~r_sck_d;
  // end of the right slot closes the frame
  assign w_frame_cmp = w_sck_rise & r_ws_prev & ~r_ws_s2;
  assign w_pair_all  = &w_pair_valid;
  assign w_chan_nxt  = r_chan + 1'b1;

  for (genvar k = 0; k < NLINES; k++) begin : g_line
    i2s_capture_writer_line_rx #(
      .SAMPLE_W (SAMPLE_W)
    ) u_line_rx (
      .i_ck         (i_ck),
      .i_rst        (i_rst),
      .i_sck_rise   (w_sck_rise),
      .i_ws         (r_ws_s2),
      .i_sd         (r_sd_s2[k]),
      .i_arm        (i_enable),
      .o_hold_l     (w_hold_l[k]),
      .o_hold_r     (w_hold_r[k]),
      .o_pair_valid (w_pair_valid[k])
    );
  end

  always_comb begin
    for (int c = 0; c < MAX_CHAN; c++) begin
      w_latch[c] = '0;
    end
    for (int k = 0; k < NLINES; k++) begin
      w_latch[2*k]   = w_hold_l[k];
      w_latch[2*k+1] = w_hold_r[k];
    end
`ifdef I2S_TEST_PATTERN_EN
    if (i_test_mode) begin
      for (int c = 0; c < CHANNELS; c++) begin
        w_latch[c] = SAMPLE_W'({c[CHAN_W-1:0], 6'b0, r_wr_ptr});
      end
    end
`endif
  end

  always_ff @(posedge i_ck or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= IDLE;
      r_chan      <= '0;
      r_wr_ptr    <= '0;
      r_frame     <= 1'b0;
      r_overrun   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      for (int c = 0; c < MAX_CHAN; c++) begin
        r_stage[c] <= '0;
      end
    end else begin
      r_frame <= 1'b0;
      if (i_clr) begin
        r_overrun <= 1'b0;
      end
      // set after clear so a coincident overrun wins
      if (w_frame_cmp && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_frame_cmp && i_enable && w_pair_all) begin
            for (int c = 0; c < MAX_CHAN; c++) begin
              r_stage[c] <= w_latch[c];
            end
            r_chan      <= '0;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= {{CHAN_W{1'b0}}, r_wr_ptr};
            r_ram_wdata <= w_latch[0];
            r_state     <= WRITE;
          end
        end
        WRITE: begin
          if (r_chan == CHAN_LAST) begin
            r_ram_we <= 1'b0;
            r_state  <= DONE;
          end else begin
            r_chan      <= w_chan_nxt;
            r_ram_addr  <= {w_chan_nxt, r_wr_ptr};
            r_ram_wdata <= r_stage[w_chan_nxt];
          end
        end
        DONE: begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_frame  <= 1'b1;
          r_state  <= IDLE;
        end
        default: begin
          r_ram_we <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign ram.ram_we    = r_ram_we;
  assign ram.ram_addr  = r_ram_addr;
  assign ram.ram_wdata = r_ram_wdata;
  assign o_wr_ptr      = r_wr_ptr;
  assign o_frame       = r_frame;
  assign o_overrun     = r_overrun;

endmodule
